// File: rtl/operand_entry.sv
// Keypad front end for the 2:1 selector: builds operands A and B from decimal
// digit strobes, drives the selector Control line and flags completion.
module operand_entry #(
    parameter int WIDTH = 8,
    parameter int RADIX = 10
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             DigitValid,
    input  logic [3:0]       Digit,
    input  logic             Next,
    output logic [WIDTH-1:0] OperandA,
    output logic [WIDTH-1:0] OperandB,
    output logic             Select,
    output logic             Ready,
    output logic             Overflow,
    output logic             BadDigit
);

    localparam int CW = WIDTH + 4;
    localparam logic [CW-1:0] LIMIT   = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [CW-1:0] RADIX_W = CW'(RADIX);
    localparam logic [4:0]    RADIX_D = 5'(RADIX);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] cur_s;
    logic [CW-1:0]    cand_s;
    logic             ovf_s;
    logic             bad_s;
    logic             entering_s;

    // Next-state, operand accumulation and flag computation.
    always_comb begin
        state_s    = state_r;
        a_s        = OperandA;
        b_s        = OperandB;
        ovf_s      = Overflow;
        bad_s      = 1'b0;
        cur_s      = OperandA;
        cand_s     = '0;
        entering_s = (state_r == ENTER_A) || (state_r == ENTER_B);

        if (state_r == ENTER_B) begin
            cur_s = OperandB;
        end else begin
            cur_s = OperandA;
        end

        // Full-width candidate so an out-of-range value is detected, never wrapped.
        cand_s = CW'(cur_s) * RADIX_W + CW'(Digit);

        if (entering_s && DigitValid) begin
            if ({1'b0, Digit} >= RADIX_D) begin
                bad_s = 1'b1;
            end else if (cand_s <= LIMIT) begin
                if (state_r == ENTER_B) begin
                    b_s = cand_s[WIDTH-1:0];
                end else begin
                    a_s = cand_s[WIDTH-1:0];
                end
            end else begin
                ovf_s = 1'b1;
            end
        end else begin
            bad_s = 1'b0;
        end

        // The digit above is applied first; a transition then clears Overflow.
        case (state_r)
            ENTER_A: begin
                if (Next) begin
                    state_s = ENTER_B;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = ENTER_A;
                end
            end
            ENTER_B: begin
                if (Next) begin
                    state_s = DONE;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = ENTER_B;
                end
            end
            DONE: begin
                if (Next) begin
                    state_s = ENTER_A;
                    ovf_s   = 1'b0;
                    a_s     = '0;
                    b_s     = '0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = ENTER_A;
                ovf_s   = 1'b0;
                a_s     = '0;
                b_s     = '0;
            end
        endcase
    end

    // State and output registers; Select/Ready follow the next state directly.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_r  <= ENTER_A;
            OperandA <= '0;
            OperandB <= '0;
            Select   <= 1'b0;
            Ready    <= 1'b0;
            Overflow <= 1'b0;
            BadDigit <= 1'b0;
        end else begin
            state_r  <= state_s;
            OperandA <= a_s;
            OperandB <= b_s;
            Select   <= (state_s == ENTER_B);
            Ready    <= (state_s == DONE);
            Overflow <= ovf_s;
            BadDigit <= bad_s;
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed test-plan steps followed by
// randomized strobes, all compared against an arithmetic reference model.
module tb_operand_entry;

    logic       Clock;
    logic       Clear;
    logic       DigitValid;
    logic [3:0] Digit;
    logic       Next;
    logic [7:0] OperandA;
    logic [7:0] OperandB;
    logic       Select;
    logic       Ready;
    logic       Overflow;
    logic       BadDigit;

    operand_entry #(.WIDTH(8), .RADIX(10)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .DigitValid (DigitValid),
        .Digit      (Digit),
        .Next       (Next),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .Select     (Select),
        .Ready      (Ready),
        .Overflow   (Overflow),
        .BadDigit   (BadDigit)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int fails = 0;

    // Reference model: 0 = entering A, 1 = entering B, 2 = done.
    int m_st  = 0;
    int m_a   = 0;
    int m_b   = 0;
    int m_ovf = 0;
    int m_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int clr, input int dv, input int dg, input int nx);
        int cand;
        if (clr != 0) begin
            m_st = 0; m_a = 0; m_b = 0; m_ovf = 0; m_bad = 0;
        end else begin
            m_bad = 0;
            if (m_st != 2 && dv != 0) begin
                if (dg >= 10) begin
                    m_bad = 1;
                end else begin
                    cand = ((m_st == 0) ? m_a : m_b) * 10 + dg;
                    if (cand <= 255) begin
                        if (m_st == 0) m_a = cand;
                        else m_b = cand;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (nx != 0) begin
                if (m_st == 2) begin
                    m_a = 0;
                    m_b = 0;
                end
                m_st  = (m_st + 1) % 3;
                m_ovf = 0;
            end
        end
    endtask

    // One clock: drive inputs away from the edge, update model, check after the edge.
    task automatic step(input int clr, input int dv, input int dg, input int nx);
        @(negedge Clock);
        Clear      = (clr != 0);
        DigitValid = (dv != 0);
        Digit      = 4'(dg);
        Next       = (nx != 0);
        @(posedge Clock);
        model_edge(clr, dv, dg, nx);
        #1;
        chk("OperandA", 32'(OperandA), 32'(m_a));
        chk("OperandB", 32'(OperandB), 32'(m_b));
        chk("Select",   32'(Select),   (m_st == 1) ? 32'd1 : 32'd0);
        chk("Ready",    32'(Ready),    (m_st == 2) ? 32'd1 : 32'd0);
        chk("Overflow", 32'(Overflow), 32'(m_ovf));
        chk("BadDigit", 32'(BadDigit), 32'(m_bad));
    endtask

    task automatic digit(input int dg);
        step(0, 1, dg, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0);
    endtask

    initial begin
        Clear      = 1'b1;
        DigitValid = 1'b0;
        Digit      = 4'd0;
        Next       = 1'b0;

        // Clear wins over simultaneous digit and Next.
        step(1, 1, 5, 1);
        chk("reset_a", 32'(OperandA), 32'd0);
        chk("reset_ready", 32'(Ready), 32'd0);

        // 123 then 45.
        digit(1); digit(2); digit(3);
        step(0, 0, 0, 1);
        chk("sel_after_next", 32'(Select), 32'd1);
        digit(4); digit(5);
        step(0, 0, 0, 1);
        chk("a_123", 32'(OperandA), 32'd123);
        chk("b_45", 32'(OperandB), 32'd45);
        chk("done_ready", 32'(Ready), 32'd1);
        idle();
        step(0, 0, 0, 1);
        chk("done_to_a_zero", 32'(OperandB), 32'd0);

        // Overflow at 256, sticky, cleared by transition.
        digit(2); digit(5); digit(6);
        chk("ovf_hold_25", 32'(OperandA), 32'd25);
        chk("ovf_set", 32'(Overflow), 32'd1);
        digit(9);
        idle();
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        step(0, 0, 0, 1);
        chk("ovf_cleared", 32'(Overflow), 32'd0);

        // Exact limit 255 accepted, then one more digit rejected.
        step(1, 0, 0, 0);
        digit(2); digit(5); digit(5);
        chk("limit_255", 32'(OperandA), 32'd255);
        chk("limit_no_ovf", 32'(Overflow), 32'd0);
        digit(0);
        chk("limit_ovf", 32'(Overflow), 32'd1);

        // Leading zeros, digit+Next together, bad digit in B, strobe in DONE.
        step(1, 0, 0, 0);
        digit(0); digit(3);
        step(0, 1, 4, 1);
        chk("merge_34", 32'(OperandA), 32'd34);
        digit(7);
        digit(12);
        chk("bad_pulse", 32'(BadDigit), 32'd1);
        chk("bad_hold_b", 32'(OperandB), 32'd7);
        idle();
        chk("bad_one_cycle", 32'(BadDigit), 32'd0);
        step(0, 0, 0, 1);
        digit(3); digit(14);
        chk("done_ignore", 32'(OperandB), 32'd7);
        step(0, 0, 0, 1);
        // Clear in the middle of B entry.
        step(0, 1, 4, 1); digit(7); digit(1);
        step(1, 0, 0, 0);
        chk("mid_clear_sel", 32'(Select), 32'd0);
        // Next held high steps one state per cycle; overflow racing a Next is hidden.
        step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
        digit(9); digit(9); step(0, 1, 9, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r_clr;
            int r_dv;
            int r_dg;
            int r_nx;
            r_clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            r_dv  = ($urandom_range(0, 2) != 0) ? 1 : 0;
            r_dg  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 15))
                                                : int'($urandom_range(0, 9));
            r_nx  = ($urandom_range(0, 6) == 0) ? 1 : 0;
            step(r_clr, r_dv, r_dg, r_nx);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
